countdown_timer: RTL and testbench
==================================

Name: countdown_timer

Overview:
- Loadable down-counter with a start/stop/done handshake; the count-down complement of the team's enable-gated up-counter.
- Software or an FSM loads a terminal count, starts it, and gates each decrement with `enable`.
- Produces a one-cycle `underflow` pulse and a sticky `done` flag when the count expires.
- Sits beside the up-counter in timing and watchdog paths; optional auto-reload gives a periodic tick.

Parameters:
- WIDTH, 4, width of `count` and `load_value`.
- AUTO_RELOAD, 0, 1 = on expiry reload from the reload register and keep running; 0 = stop in DONE.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  reset, synchronous, active-high.
- load  input  1  capture `load_value` into `count` and the reload register.
- load_value  input  WIDTH  terminal count to load.
- start  input  1  begin or resume counting.
- stop  input  1  pause counting, holding `count`.
- enable  input  1  decrement qualifier, sampled only in RUN.
- count  output  WIDTH  current count value, registered.
- busy  output  1  high while in RUN.
- done  output  1  high while in DONE.
- underflow  output  1  one-cycle pulse on expiry.

Behaviour:
- Reset (rst high at an edge): count=0, reload register=0, state=IDLE, busy=0, done=0, underflow=0. Reset overrides every other input, including in mid-run.
- All outputs are registered. Each input is sampled at an edge and its effect is visible immediately after that edge (latency 1).
- States: IDLE, ARMED, RUN, DONE. `busy` = (state==RUN); `done` = (state==DONE).
- Priority at each edge: rst > load > stop > start > enable.
- load, any state: count and reload register take `load_value`; state goes to ARMED; underflow=0. A `start` in the same cycle is ignored.
- IDLE: `start`, `stop` and `enable` are ignored.
- ARMED: on `start`:
  - count != 0: go to RUN.
  - count == 0: go to DONE and pulse underflow.
- RUN, stop: go to ARMED, count held, no decrement even if `enable` is high.
- RUN, enable with count > 1: count decrements by 1.
- RUN, enable with count == 1:
  - AUTO_RELOAD=0: count becomes 0, go to DONE, underflow=1 for exactly that cycle.
  - AUTO_RELOAD=1: count becomes the reload register value, stay in RUN, underflow=1 for that cycle.
  - Reload register == 1 gives an underflow every enabled cycle.
  - Reload register == 0 cannot occur in RUN, because a start with count 0 never enters RUN.
- RUN, enable low: count held.
- DONE:
  - count stays 0.
  - `start` reloads count from the reload register and goes to RUN, or back to DONE with a fresh underflow pulse if the reload register is 0.
  - `stop` is ignored.
- underflow is low in every cycle not named above; it never stays high for two cycles except on back-to-back reload-1 expiries.
- Arithmetic: unsigned, WIDTH bits. The decrement never wraps below 0. Load of all-ones is legal (15 for WIDTH=4).

Decomposition:
- Shared package `countdown_pkg` holds:
  - 2-bit state typedef: IDLE=0, ARMED=1, RUN=2, DONE=3.
  - Default-width constant.
- No sub-module; single always block for the state and count, plus continuous assigns for `busy` and `done`.

Test Plan:
- Basic expiry: load 3, start, hold enable -> count 3,2,1,0 on successive edges; underflow high only on the edge reaching 0; done=1, busy=0 afterwards.
- Pause and resume: load 4'hF, start, 4 enabled cycles -> count 4'hB; assert stop together with enable -> ARMED, count stays 4'hB; start -> RUN, decrements resume.
- Load priority: load=1, load_value=6, start=1 in the same cycle -> state ARMED, count=6, busy=0; next-cycle start -> busy=1.
- Zero load: load 0, start -> next cycle done=1, underflow pulse exactly one cycle, count=0, busy never high.
- Auto-reload (AUTO_RELOAD=1): load 2, start, enable held -> count 2,1,2,1,... with underflow on every edge that reloads to 2; busy stays 1.
- Reset mid-run: load 5, start, 2 enables (count=3), then rst=1 -> next edge count=0, state IDLE, busy=0, done=0, underflow=0; a subsequent start without load is ignored.

Source files
------------

// File: rtl/countdown_pkg.sv
// Shared types and constants for the loadable countdown timer.
package countdown_pkg;

  // Timer control states; the encoding is fixed so software and debug views agree.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Default width of the count and load value.
  localparam int DEFAULT_WIDTH = 4;

endpackage : countdown_pkg

// File: rtl/countdown_timer.sv
// Loadable down-counter with start/stop/done handshake, enable-gated
// decrement, one-cycle underflow pulse and optional auto-reload.
module countdown_timer
  import countdown_pkg::*;
#(
  parameter int WIDTH       = DEFAULT_WIDTH,
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             start,
  input  logic             stop,
  input  logic             enable,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             underflow
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             underflow_q, underflow_d;

  // Next-state, next-count and underflow decode in priority order load > stop > start > enable.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    state_d     = state_q;
    count_d     = count_q;
    reload_d    = reload_q;
    underflow_d = 1'b0;

    if (load) begin
      // A load always re-arms, discarding any start in the same cycle.
      count_d  = load_value;
      reload_d = load_value;
      state_d  = ARMED;
    end else begin
      unique case (state_q)
        IDLE: begin
          // Nothing happens until a value has been loaded.
        end

        ARMED: begin
          if (!stop && start) begin
            if (count_q != '0) begin
              state_d = RUN;
            end else begin
              // A zero count expires immediately instead of entering RUN.
              state_d     = DONE;
              underflow_d = 1'b1;
            end
          end
        end

        RUN: begin
          if (stop) begin
            state_d = ARMED;
          end else if (enable) begin
            if (count_q == WIDTH'(1)) begin
              underflow_d = 1'b1;
              if (AUTO_RELOAD) begin
                count_d = reload_q;
              end else begin
                count_d = '0;
                state_d = DONE;
              end
            end else if (count_q != '0) begin
              // Guarded so the count can never wrap below zero.
              count_d = count_q - WIDTH'(1);
            end
          end
        end

        DONE: begin
          if (start) begin
            if (reload_q != '0) begin
              count_d = reload_q;
              state_d = RUN;
            end else begin
              // Restarting with a zero reload value expires again at once.
              underflow_d = 1'b1;
            end
          end
        end

        default: state_d = IDLE;
      endcase
    end
  end

  // State, count, reload register and underflow flops with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: reset is sampled on the clock edge and uses non-blocking assignments like all state.
    if (rst) begin
      state_q     <= IDLE;
      count_q     <= '0;
      reload_q    <= '0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      reload_q    <= reload_d;
      underflow_q <= underflow_d;
    end
  end

  assign count     = count_q;
  assign underflow = underflow_q;
  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);

endmodule : countdown_timer

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer: a one-shot instance driven from a
// vector table, plus hand-written auto-reload and mid-run reset sequences.
module tb_countdown_timer;

  logic       clk = 1'b0;
  logic       rst;
  logic       load;
  logic [3:0] load_value;
  logic       start;
  logic       stop;
  logic       enable;

  logic [3:0] count0, count1;
  logic       busy0, busy1;
  logic       done0, done1;
  logic       uf0, uf1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  countdown_timer #(.WIDTH(4), .AUTO_RELOAD(1'b0)) u_oneshot (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .load_value (load_value),
    .start      (start),
    .stop       (stop),
    .enable     (enable),
    .count      (count0),
    .busy       (busy0),
    .done       (done0),
    .underflow  (uf0)
  );

  countdown_timer #(.WIDTH(4), .AUTO_RELOAD(1'b1)) u_reload (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .load_value (load_value),
    .start      (start),
    .stop       (stop),
    .enable     (enable),
    .count      (count1),
    .busy       (busy1),
    .done       (done1),
    .underflow  (uf1)
  );

  typedef struct packed {
    logic       ld;
    logic [3:0] lv;
    logic       st;
    logic       sp;
    logic       en;
    logic [3:0] exp_count;
    logic       exp_busy;
    logic       exp_done;
    logic       exp_uf;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Apply one cycle of inputs, then sample 1 time unit after the edge.
  task automatic step(input logic ld, input logic [3:0] lv, input logic st,
                      input logic sp, input logic en);
    load       = ld;
    load_value = lv;
    start      = st;
    stop       = sp;
    enable     = en;
    @(posedge clk);
    #1;
  endtask

  task automatic check0(input string tag, input logic [3:0] c, input logic b,
                        input logic d, input logic u);
    check({tag, " count"},     {28'd0, count0}, {28'd0, c});
    check({tag, " busy"},      {31'd0, busy0},  {31'd0, b});
    check({tag, " done"},      {31'd0, done0},  {31'd0, d});
    check({tag, " underflow"}, {31'd0, uf0},    {31'd0, u});
  endtask

  task automatic check1(input string tag, input logic [3:0] c, input logic b,
                        input logic d, input logic u);
    check({tag, " count"},     {28'd0, count1}, {28'd0, c});
    check({tag, " busy"},      {31'd0, busy1},  {31'd0, b});
    check({tag, " done"},      {31'd0, done1},  {31'd0, d});
    check({tag, " underflow"}, {31'd0, uf1},    {31'd0, u});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
  endtask

  initial begin
    // ld, lv, st, sp, en | count, busy, done, underflow
    // IDLE ignores start and enable
    vecs.push_back('{1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0});
    // Basic expiry from 3
    vecs.push_back('{1'b1, 4'h3, 1'b0, 1'b0, 1'b0, 4'h3, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 4'h3, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 4'h2, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 4'h1, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 4'h0, 1'b0, 1'b1, 1'b1});
    vecs.push_back('{1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 4'h0, 1'b0, 1'b1, 1'b0});
    // DONE ignores stop; start reloads from the reload register
    vecs.push_back('{1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 4'h3, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 4'h2, 1'b1, 1'b0, 1'b0});
    // Pause and resume from all-ones
    vecs.push_back('{1'b1, 4'hF, 1'b0, 1'b0, 1'b0, 4'hF, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 4'hF, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 4'hE, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 4'hD, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 4'hC, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 4'hB, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 4'hB, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 4'hB, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 4'hB, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 4'hA, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 4'hA, 1'b1, 1'b0, 1'b0});
    // Load beats a same-cycle start
    vecs.push_back('{1'b1, 4'h6, 1'b1, 1'b0, 1'b0, 4'h6, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 4'h6, 1'b1, 1'b0, 1'b0});
    // Zero load expires immediately; restart from DONE with reload 0 pulses again
    vecs.push_back('{1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1});
    vecs.push_back('{1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1});
    vecs.push_back('{1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0});
    // Load from DONE, then single-step expiry from 1
    vecs.push_back('{1'b1, 4'h1, 1'b0, 1'b0, 1'b0, 4'h1, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 4'h1, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 4'h0, 1'b0, 1'b1, 1'b1});

    load = 1'b0; load_value = 4'h0; start = 1'b0; stop = 1'b0; enable = 1'b0;
    do_reset();
    check0("reset", 4'h0, 1'b0, 1'b0, 1'b0);
    check1("reset ar", 4'h0, 1'b0, 1'b0, 1'b0);

    foreach (vecs[i]) begin
      step(vecs[i].ld, vecs[i].lv, vecs[i].st, vecs[i].sp, vecs[i].en);
      check0($sformatf("vec%0d", i), vecs[i].exp_count, vecs[i].exp_busy,
             vecs[i].exp_done, vecs[i].exp_uf);
    end

    // Auto-reload with reload value 2: 2,1,2,1,... underflow on each reload
    do_reset();
    step(1'b1, 4'h2, 1'b0, 1'b0, 1'b0);
    check1("ar load2", 4'h2, 1'b0, 1'b0, 1'b0);
    step(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    check1("ar start", 4'h2, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
      check1($sformatf("ar dec%0d", k), 4'h1, 1'b1, 1'b0, 1'b0);
      step(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
      check1($sformatf("ar reload%0d", k), 4'h2, 1'b1, 1'b0, 1'b1);
    end
    step(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    check1("ar hold", 4'h2, 1'b1, 1'b0, 1'b0);

    // Auto-reload with reload value 1: underflow on every enabled cycle
    step(1'b1, 4'h1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    check1("ar1 start", 4'h1, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
      check1($sformatf("ar1 tick%0d", k), 4'h1, 1'b1, 1'b0, 1'b1);
    end
    step(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    check1("ar1 idle", 4'h1, 1'b1, 1'b0, 1'b0);

    // Reset in mid-run overrides start/enable; later start without load is ignored
    do_reset();
    step(1'b1, 4'h5, 1'b0, 1'b0, 1'b0);
    step(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
    check0("pre-rst", 4'h3, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    step(1'b0, 4'h0, 1'b1, 1'b0, 1'b1);
    rst = 1'b0;
    check0("mid-rst", 4'h0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 4'h0, 1'b1, 1'b0, 1'b1);
    check0("post-rst start", 4'h0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
    check0("post-rst enable", 4'h0, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_countdown_timer
